// File: rtl/bridge_src_arbiter_pkg.sv
// Shared types for the bridge source-side arbiter: FSM encoding and transfer direction codes.
// The direction codes match the source controller's rd0_wr1 convention.
package bridge_src_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_SLEEP   = 2'd3
    } arb_state_t;

    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

    localparam int TMO_W = 8;

endpackage

// File: rtl/bridge_src_arbiter_rr_pick.sv
// Rotate-priority encoder: first asserted request at or after ptr, wrapping.
// Purely combinational, no backpressure.
module rr_pick #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W:0] cand;

    // Walk from farthest to nearest so the candidate closest to ptr wins.
    always_comb begin
        any  = |req;
        idx  = '0;
        cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (cand >= (IDX_W + 1)'(NUM_REQ)) begin
                cand = cand - (IDX_W + 1)'(NUM_REQ);
            end
            if (req[cand[IDX_W-1:0]]) begin
                idx = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/bridge_src_arbiter.sv
// Round-robin arbiter sharing the bridge source port between NUM_REQ masters; grant held across reads.
// Request sampled in IDLE at N, o_valid at N+1; masters hold fields until o_req_ready, sleep blocks new grants.
module bridge_src_arbiter
    import bridge_src_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                            i_clk_src,
    input  logic                            i_rstn_src,
    input  logic [NUM_REQ-1:0]              i_req_valid,
    input  logic [NUM_REQ-1:0]              i_req_rd0_wr1,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   i_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_wr_data,
    output logic [NUM_REQ-1:0]              o_req_ready,
    output logic [DATA_WIDTH-1:0]           o_rsp_rd_data,
    output logic [NUM_REQ-1:0]              o_rsp_rd_valid,
    output logic [NUM_REQ-1:0]              o_rsp_err,
    output logic                            o_rd0_wr1,
    output logic [ADDR_WIDTH-1:0]           o_addr,
    output logic                            o_valid,
    output logic [DATA_WIDTH-1:0]           o_wr_data,
    input  logic                            i_ready,
    input  logic [DATA_WIDTH-1:0]           i_rd_data,
    input  logic                            i_rd_valid,
    input  logic                            i_src_sleep_sts
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         state;
    logic [IDX_W-1:0]   grant;
    logic [IDX_W-1:0]   rr_ptr;
    logic [TMO_W-1:0]   tmo_cnt;

    logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdat_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i] = i_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdat_arr[i] = i_req_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req (i_req_valid),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    logic               in_grant;
    logic               in_wait;
    logic               grant_vld;
    logic               xfer;
    logic               rsp_hit;
    logic               tmo_hit;
    logic [NUM_REQ-1:0] grant_oh;
    logic [IDX_W-1:0]   grant_nxt;

    always_comb begin
        grant_oh        = '0;
        grant_oh[grant] = 1'b1;
    end

    assign in_grant  = (state == ST_GRANT);
    assign in_wait   = (state == ST_RD_WAIT);
    assign grant_vld = i_req_valid[grant];
    assign xfer      = in_grant & grant_vld & i_ready;
    assign rsp_hit   = in_wait & i_rd_valid;
    // Data arriving on the last allowed cycle takes precedence over the abort.
    assign tmo_hit   = in_wait & ~i_rd_valid & (tmo_cnt == TMO_W'(TIMEOUT - 1));
    assign grant_nxt = (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

    assign o_valid        = in_grant & grant_vld;
    assign o_rd0_wr1      = in_grant ? i_req_rd0_wr1[grant] : DIR_WR;
    assign o_addr         = in_grant ? addr_arr[grant] : '0;
    assign o_wr_data      = in_grant ? wdat_arr[grant] : '0;
    assign o_req_ready    = xfer    ? grant_oh : '0;
    assign o_rsp_rd_valid = rsp_hit ? grant_oh : '0;
    assign o_rsp_rd_data  = rsp_hit ? i_rd_data : '0;
    assign o_rsp_err      = tmo_hit ? grant_oh : '0;

    always_ff @(posedge i_clk_src or negedge i_rstn_src) begin
        if (!i_rstn_src) begin
            state   <= ST_IDLE;
            grant   <= '0;
            rr_ptr  <= '0;
            tmo_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_src_sleep_sts) begin
                        state <= ST_SLEEP;
                    end else if (pick_any) begin
                        grant <= pick_idx;
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // A master withdrawing its request releases the grant without moving the pointer.
                    if (!grant_vld) begin
                        state <= ST_IDLE;
                    end else if (i_ready) begin
                        rr_ptr <= grant_nxt;
                        if (i_req_rd0_wr1[grant] == DIR_RD) begin
                            state   <= ST_RD_WAIT;
                            tmo_cnt <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (i_rd_valid || tmo_hit) begin
                        state <= ST_IDLE;
                    end
                end
                ST_SLEEP: begin
                    if (!i_src_sleep_sts) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
